// File: rtl/shift_reg_ctrl.sv
// Purpose : parallel-to-serial shift controller; accepts a WIDTH-bit word and
//           streams it out one bit per cycle, LSB or MSB first.
// Latency : first bit valid the cycle after accept; done pulses one cycle after
//           the last bit; ready again one cycle after done (WIDTH+2 per word).
// Backpressure: load_ready is low while a word is in flight; hold freezes the
//           stream for as many cycles as it stays high (sout_valid drops meanwhile).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   load_valid/_ready parallel word handshake, load_data is the word
//   hold              stall request, only meaningful while shifting
//   sout, sout_valid  serial bit and its qualifier
//   busy, done        transfer in progress / one-cycle end-of-word pulse
module shift_reg_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;

    // Bit presented at the output end of the register.
    logic             out_bit;
    // Register after one shift toward the output end, zero filled.
    logic [WIDTH-1:0] shreg_shifted;

    always_comb begin
        if (MSB_FIRST) begin
            out_bit       = shreg_q[WIDTH-1];
            shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            out_bit       = shreg_q[0];
            shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        count_d    = count_q;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shreg_d = load_data;
                    count_d = CW'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                busy       = 1'b1;
                // sout stays driven while held so the line does not glitch;
                // only the qualifier drops.
                sout       = out_bit;
                sout_valid = ~hold;
                if (!hold) begin
                    shreg_d = shreg_shifted;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the shift word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 0, where 0 means LSB shifted out first and 1 means MSB shifted out first.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port load_valid, input, 1 bit: requester offers a parallel word.
REQ-006 The block SHALL have port load_data, input, WIDTH bits: parallel word to serialise.
REQ-007 The block SHALL have port load_ready, output, 1 bit: controller can accept a word.
REQ-008 The block SHALL have port hold, input, 1 bit: stall request; freezes shifting while high.
REQ-009 The block SHALL have port sout, output, 1 bit: current serial bit.
REQ-010 The block SHALL have port sout_valid, output, 1 bit: sout carries a valid bit this cycle.
REQ-011 The block SHALL have port busy, output, 1 bit: high in SHIFT and DONE states.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT and DONE, with a WIDTH-bit shift register and a bit counter of width clog2(WIDTH+1).
REQ-014 In IDLE, load_ready SHALL be 1; on a rising edge with load_valid=1 the block SHALL capture load_data, set count=WIDTH and enter SHIFT.
REQ-015 In SHIFT and DONE, load_ready SHALL be 0, and load_valid/load_data SHALL be ignored with no capture and no effect on the stream in progress.
REQ-016 In SHIFT, sout SHALL equal shreg[0] when MSB_FIRST=0 and shreg[WIDTH-1] when MSB_FIRST=1.
REQ-017 In SHIFT, sout_valid SHALL be 1 exactly when hold=0.
REQ-018 On each SHIFT edge with hold=0, the block SHALL shift the register one position toward the output end, fill with 0 and decrement count.
REQ-019 On each SHIFT edge with hold=1, the register and count SHALL remain unchanged, and sout SHALL keep its value with sout_valid=0.
REQ-020 When a SHIFT edge with hold=0 takes count from 1 to 0, the block SHALL enter DONE.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-022 Timing with no holds, for an accept edge at cycle N: bits SHALL be valid in cycles N+1..N+WIDTH, done SHALL be high in cycle N+WIDTH+1, and load_ready SHALL be high again in cycle N+WIDTH+2.
REQ-023 Each cycle of hold=1 in SHIFT SHALL delay all subsequent events by exactly one cycle.
REQ-024 hold SHALL have no effect in IDLE or DONE.
REQ-025 A held-high load_valid SHALL cause back-to-back words to be accepted every WIDTH+2 cycles.
REQ-026 In IDLE and DONE, sout_valid SHALL be 0 and sout SHALL be 0.
REQ-027 busy SHALL be 1 exactly in SHIFT and DONE.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL enter IDLE and clear the shift register and count to 0.
REQ-029 While in reset, the outputs SHALL be: load_ready=1 after the reset edge, sout=0, sout_valid=0, busy=0, done=0.
REQ-030 A reset asserted in SHIFT or DONE SHALL abort the transfer, with no done pulse and no further sout_valid for that word.
REQ-031 rst SHALL take priority over load_valid and hold in the same cycle.

Verification
REQ-032 Bench SHALL check: WIDTH=8, MSB_FIRST=0, accept 0xC4 at cycle N -> sout 0,0,1,0,0,0,1,1 in cycles N+1..N+8, done in N+9, load_ready=1 in N+10.
REQ-033 Bench SHALL check: MSB_FIRST=1, accept 0xC4 -> sout 1,1,0,0,0,1,0,0, done in N+9.
REQ-034 Bench SHALL check: MSB_FIRST=0, 0xC4, hold=1 for cycles N+3..N+5 -> valid bit sequence unchanged, sout_valid=0 in those 3 cycles, done in N+12.
REQ-035 Bench SHALL check: load_valid=1 with 0xFF during SHIFT of 0xC4 -> load_ready=0, stream still 0,0,1,0,0,0,1,1, and 0xFF is never emitted.
REQ-036 Bench SHALL check: rst=1 at cycle N+4 of a transfer -> next cycle IDLE with load_ready=1, sout_valid=0, busy=0, and no done pulse.
REQ-037 Bench SHALL check: load_valid held high with 0x01 then 0x80 -> accepts at N and N+10, each followed by done at N+9 and N+19.
